// File: rtl/line_draw_pkg.sv
// Shared types and screen constants for the Bresenham line drawer.
package line_draw_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned DEF_X_W  = 10;
  localparam int unsigned DEF_Y_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/line_setup.sv
// Combinational line setup: octant fold (steep swap), endpoint ordering along
// the major axis, deltas, minor-axis step direction and initial error term.
module line_setup
  import line_draw_pkg::*;
#(
  parameter int unsigned X_W = DEF_X_W,
  parameter int unsigned Y_W = DEF_Y_W,
  parameter int unsigned CW  = ((X_W > Y_W) ? X_W : Y_W) + 2
) (
  input  logic [X_W-1:0]       x0,
  input  logic [X_W-1:0]       x1,
  input  logic [Y_W-1:0]       y0,
  input  logic [Y_W-1:0]       y1,
  output logic                 steep_c,
  output logic                 ystep_pos_c,
  output logic signed [CW-1:0] major0_c,
  output logic signed [CW-1:0] major1_c,
  output logic signed [CW-1:0] minor0_c,
  output logic signed [CW-1:0] dx_c,
  output logic signed [CW-1:0] dy_c,
  output logic signed [CW-1:0] err_c
);

  logic signed [CW-1:0] ex0, ex1, ey0, ey1;
  logic signed [CW-1:0] adx, ady;
  logic signed [CW-1:0] a0, a1, b0, b1;
  logic signed [CW-1:0] m0, m1, n0, n1;

  assign ex0 = $signed(CW'(x0));
  assign ex1 = $signed(CW'(x1));
  assign ey0 = $signed(CW'(y0));
  assign ey1 = $signed(CW'(y1));

  always_comb begin
    adx     = (ex1 >= ex0) ? (ex1 - ex0) : (ex0 - ex1);
    ady     = (ey1 >= ey0) ? (ey1 - ey0) : (ey0 - ey1);
    steep_c = (ady > adx);

    a0 = steep_c ? ey0 : ex0;
    a1 = steep_c ? ey1 : ex1;
    b0 = steep_c ? ex0 : ey0;
    b1 = steep_c ? ex1 : ey1;

    // Walk the major axis upward only, so reversed lines swap endpoints.
    if (a0 > a1) begin
      m0 = a1;
      m1 = a0;
      n0 = b1;
      n1 = b0;
    end else begin
      m0 = a0;
      m1 = a1;
      n0 = b0;
      n1 = b1;
    end

    major0_c    = m0;
    major1_c    = m1;
    minor0_c    = n0;
    dx_c        = m1 - m0;
    dy_c        = (n1 >= n0) ? (n1 - n0) : (n0 - n1);
    ystep_pos_c = (n1 > n0);
    err_c       = dx_c >>> 1;
  end

endmodule

// File: rtl/bresenham_line_drawer.sv
// Bresenham line generator: one framebuffer write per cycle along the path.
// Optional LINE_DRAWER_READY_EN adds a pixel_ready back-pressure input.
module bresenham_line_drawer
  import line_draw_pkg::*;
#(
  parameter int unsigned X_W = DEF_X_W,
  parameter int unsigned Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic           color_in,
`ifdef LINE_DRAWER_READY_EN
  input  logic           pixel_ready,
`endif
  output logic           busy,
  output logic           pixel_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           color,
  output logic           done
);

  localparam int unsigned CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  ld_state_t state, state_nxt;

  logic [X_W-1:0] x0_q, x1_q, x0_nxt, x1_nxt;
  logic [Y_W-1:0] y0_q, y1_q, y0_nxt, y1_nxt;
  logic           color_q, color_q_nxt;

  logic steep_q, steep_nxt, ystep_pos_q, ystep_pos_nxt;
  logic signed [CW-1:0] major_q, major1_q, minor_q, dx_q, dy_q, err_q;
  logic signed [CW-1:0] major_nxt, major1_nxt, minor_nxt, dx_nxt, dy_nxt, err_nxt;
  logic signed [CW-1:0] err_dec_c;

  logic           busy_nxt, pixel_valid_nxt, color_nxt, done_nxt;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           ready_c, adv_c;

  logic                 s_steep_c, s_ystep_pos_c;
  logic signed [CW-1:0] s_major0_c, s_major1_c, s_minor0_c, s_dx_c, s_dy_c, s_err_c;

`ifdef LINE_DRAWER_READY_EN
  assign ready_c = pixel_ready;
`else
  assign ready_c = 1'b1;
`endif

  // A held (valid, not ready) pixel freezes the walk and the outputs.
  assign adv_c = !pixel_valid || ready_c;

  line_setup #(.X_W(X_W), .Y_W(Y_W), .CW(CW)) u_setup (
    .x0          (x0_q),
    .x1          (x1_q),
    .y0          (y0_q),
    .y1          (y1_q),
    .steep_c     (s_steep_c),
    .ystep_pos_c (s_ystep_pos_c),
    .major0_c    (s_major0_c),
    .major1_c    (s_major1_c),
    .minor0_c    (s_minor0_c),
    .dx_c        (s_dx_c),
    .dy_c        (s_dy_c),
    .err_c       (s_err_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    x0_nxt          = x0_q;
    x1_nxt          = x1_q;
    y0_nxt          = y0_q;
    y1_nxt          = y1_q;
    color_q_nxt     = color_q;
    steep_nxt       = steep_q;
    ystep_pos_nxt   = ystep_pos_q;
    major_nxt       = major_q;
    major1_nxt      = major1_q;
    minor_nxt       = minor_q;
    dx_nxt          = dx_q;
    dy_nxt          = dy_q;
    err_nxt         = err_q;
    busy_nxt        = busy;
    pixel_valid_nxt = pixel_valid;
    x_nxt           = x;
    y_nxt           = y;
    color_nxt       = color;
    done_nxt        = 1'b0;
    err_dec_c       = err_q - dy_q;

    unique case (state)
      IDLE: begin
        busy_nxt        = 1'b0;
        pixel_valid_nxt = 1'b0;
        if (start) begin
          state_nxt   = SETUP;
          busy_nxt    = 1'b1;
          x0_nxt      = x0;
          x1_nxt      = x1;
          y0_nxt      = y0;
          y1_nxt      = y1;
          color_q_nxt = color_in;
        end
      end
      SETUP: begin
        steep_nxt     = s_steep_c;
        ystep_pos_nxt = s_ystep_pos_c;
        major_nxt     = s_major0_c;
        major1_nxt    = s_major1_c;
        minor_nxt     = s_minor0_c;
        dx_nxt        = s_dx_c;
        dy_nxt        = s_dy_c;
        err_nxt       = s_err_c;
        state_nxt     = DRAW;
      end
      DRAW: begin
        if (adv_c) begin
          pixel_valid_nxt = 1'b1;
          x_nxt           = steep_q ? minor_q[X_W-1:0] : major_q[X_W-1:0];
          y_nxt           = steep_q ? major_q[Y_W-1:0] : minor_q[Y_W-1:0];
          color_nxt       = color_q;
          major_nxt       = major_q + ONE;
          if (err_dec_c[CW-1]) begin
            minor_nxt = ystep_pos_q ? (minor_q + ONE) : (minor_q - ONE);
            err_nxt   = err_dec_c + dx_q;
          end else begin
            err_nxt   = err_dec_c;
          end
          if (major_q == major1_q) state_nxt = DONE;
        end
      end
      DONE: begin
        if (adv_c) begin
          pixel_valid_nxt = 1'b0;
          done_nxt        = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= 1'b0;
      steep_q     <= 1'b0;
      ystep_pos_q <= 1'b0;
      major_q     <= '0;
      major1_q    <= '0;
      minor_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      busy        <= 1'b0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      x0_q        <= x0_nxt;
      x1_q        <= x1_nxt;
      y0_q        <= y0_nxt;
      y1_q        <= y1_nxt;
      color_q     <= color_q_nxt;
      steep_q     <= steep_nxt;
      ystep_pos_q <= ystep_pos_nxt;
      major_q     <= major_nxt;
      major1_q    <= major1_nxt;
      minor_q     <= minor_nxt;
      dx_q        <= dx_nxt;
      dy_q        <= dy_nxt;
      err_q       <= err_nxt;
      busy        <= busy_nxt;
      pixel_valid <= pixel_valid_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      color       <= color_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer; ready handshake exercised when
// LINE_DRAWER_READY_EN is defined.
module tb_bresenham_line_drawer;
  import line_draw_pkg::*;

  typedef struct packed {
    logic [9:0]       x0;
    logic [8:0]       y0;
    logic [9:0]       x1;
    logic [8:0]       y1;
    logic             c;
    logic [3:0]       n;
    logic [7:0][9:0]  ex;
    logic [7:0][8:0]  ey;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x0 = '0, x1 = '0;
  logic [8:0] y0 = '0, y1 = '0;
  logic       color_in = 1'b0;
  logic       busy, pixel_valid, color, done;
  logic [9:0] x;
  logic [8:0] y;
`ifdef LINE_DRAWER_READY_EN
  logic       pixel_ready = 1'b1;
  int         acc = 0;
  always @(posedge clk) if (pixel_valid && pixel_ready) acc++;
`endif

  int   total = 0;
  int   bad = 0;
  vec_t vecs [5];
  int   nv = 0;

  always #5 clk = ~clk;

  bresenham_line_drawer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .x0          (x0),
    .x1          (x1),
    .y0          (y0),
    .y1          (y1),
    .color_in    (color_in),
`ifdef LINE_DRAWER_READY_EN
    .pixel_ready (pixel_ready),
`endif
    .busy        (busy),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .color       (color),
    .done        (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    vecs[nv]    = '0;
    vecs[nv].x0 = 10'(ax0);
    vecs[nv].y0 = 9'(ay0);
    vecs[nv].x1 = 10'(ax1);
    vecs[nv].y1 = 9'(ay1);
    vecs[nv].c  = 1'(c);
    nv++;
  endtask

  task automatic add_px(input int px, input int py);
    vecs[nv-1].ex[vecs[nv-1].n] = 10'(px);
    vecs[nv-1].ey[vecs[nv-1].n] = 9'(py);
    vecs[nv-1].n = vecs[nv-1].n + 4'd1;
  endtask

  task automatic drive_start(input int ax0, input int ay0, input int ax1, input int ay1, input logic c);
    @(negedge clk);
    x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1);
    color_in = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full protocol check of one line: busy, setup gap, pixels, done, idle.
  task automatic run_vec(input vec_t v, input string tag);
    drive_start(int'(v.x0), int'(v.y0), int'(v.x1), int'(v.y1), v.c);
    chk({tag, ".busy_rise"}, 32'(busy), 1);
    chk({tag, ".pv_idle"}, 32'(pixel_valid), 0);
    @(negedge clk);
    chk({tag, ".pv_setup"}, 32'(pixel_valid), 0);
    for (int k = 0; k < int'(v.n); k++) begin
      @(negedge clk);
      chk($sformatf("%s.pv%0d", tag, k), 32'(pixel_valid), 1);
      chk($sformatf("%s.x%0d", tag, k), 32'(x), 32'(v.ex[k]));
      chk($sformatf("%s.y%0d", tag, k), 32'(y), 32'(v.ey[k]));
      chk($sformatf("%s.c%0d", tag, k), 32'(color), 32'(v.c));
      chk($sformatf("%s.nodone%0d", tag, k), 32'(done), 0);
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".pv_done"}, 32'(pixel_valid), 0);
    chk({tag, ".busy_done"}, 32'(busy), 1);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done), 0);
    chk({tag, ".busy_fall"}, 32'(busy), 0);
  endtask

  initial begin
    add_vec(0, 0, 3, 0, 1);
    add_px(0, 0); add_px(1, 0); add_px(2, 0); add_px(3, 0);
    add_vec(2, 5, 0, 0, 1);
    add_px(0, 0); add_px(0, 1); add_px(1, 2); add_px(1, 3); add_px(2, 4); add_px(2, 5);
    add_vec(7, 9, 7, 9, 1);
    add_px(7, 9);
    add_vec(0, 0, 5, 2, 0);
    add_px(0, 0); add_px(1, 0); add_px(2, 1); add_px(3, 1); add_px(4, 2); add_px(5, 2);
    add_vec(6, 1, 0, 4, 1);
    add_px(0, 4); add_px(1, 4); add_px(2, 3); add_px(3, 3); add_px(4, 2); add_px(5, 2); add_px(6, 1);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.pv", 32'(pixel_valid), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.x", 32'(x), 0);
    chk("rst.y", 32'(y), 0);
    chk("rst.color", 32'(color), 0);
    reset_n = 1'b1;

    for (int i = 0; i < nv; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Clear column with an ignored mid-line start
    drive_start(SCREEN_W - 1, 0, SCREEN_W - 1, SCREEN_H - 1, 1'b0);
    chk("clr.busy_rise", 32'(busy), 1);
    @(negedge clk);
    chk("clr.pv_setup", 32'(pixel_valid), 0);
    for (int k = 0; k < int'(SCREEN_H); k++) begin
      @(negedge clk);
      chk($sformatf("clr.pv%0d", k), 32'(pixel_valid), 1);
      chk($sformatf("clr.x%0d", k), 32'(x), SCREEN_W - 1);
      chk($sformatf("clr.y%0d", k), 32'(y), 32'(k));
      chk($sformatf("clr.busy%0d", k), 32'(busy), 1);
      if (k == 100) begin
        x0 = 10'd5; y0 = 9'd5; x1 = 10'd6; y1 = 9'd6; color_in = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("clr.color", 32'(color), 0);
    @(negedge clk);
    chk("clr.done", 32'(done), 1);
    chk("clr.busy_done", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("clr.idle_pv%0d", k), 32'(pixel_valid), 0);
      chk($sformatf("clr.idle_busy%0d", k), 32'(busy), 0);
    end

    // Asynchronous reset mid-line at pixel 3 of a diagonal
    drive_start(0, 0, 10, 10, 1'b1);
    repeat (4) @(negedge clk);
    chk("arst.pre_x", 32'(x), 2);
    chk("arst.pre_y", 32'(y), 2);
    chk("arst.pre_pv", 32'(pixel_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 0);
    chk("arst.pv", 32'(pixel_valid), 0);
    chk("arst.done", 32'(done), 0);
    chk("arst.x", 32'(x), 0);
    chk("arst.y", 32'(y), 0);
    chk("arst.color", 32'(color), 0);
    chk("arst.state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst.post_busy", 32'(busy), 0);
    chk("arst.post_pv", 32'(pixel_valid), 0);
    run_vec(vecs[1], "arst_fresh");

`ifdef LINE_DRAWER_READY_EN
    begin
      int acc0;
      acc0 = acc;
      drive_start(0, 0, 2, 2, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("rdy.x0", 32'(x), 0);
      chk("rdy.y0", 32'(y), 0);
      @(negedge clk);
      chk("rdy.x1", 32'(x), 1);
      chk("rdy.y1", 32'(y), 1);
      pixel_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("rdy.hold_pv%0d", k), 32'(pixel_valid), 1);
        chk($sformatf("rdy.hold_x%0d", k), 32'(x), 1);
        chk($sformatf("rdy.hold_y%0d", k), 32'(y), 1);
        chk($sformatf("rdy.hold_done%0d", k), 32'(done), 0);
      end
      pixel_ready = 1'b1;
      @(negedge clk);
      chk("rdy.x2", 32'(x), 2);
      chk("rdy.y2", 32'(y), 2);
      chk("rdy.pv2", 32'(pixel_valid), 1);
      @(negedge clk);
      chk("rdy.done", 32'(done), 1);
      chk("rdy.accepted", 32'(acc - acc0), 3);
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
